// File: rtl/ooo_completion_buffer.sv
// Out-of-order completion buffer: dispatch reserves entries in program order,
// functional units complete them by index in any order, and the head entry
// retires in order (register write, commit PC) or raises a flush on exception.
module ooo_completion_buffer #(
    parameter int NUM_CB_ENTRY = 16,
    localparam int IDX_W = $clog2(NUM_CB_ENTRY)
) (
    input  logic             CLK,
    input  logic             nRST,
    // Dispatch side
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [IDX_W-1:0] alloc_index,
    output logic             full,
    output logic             empty,
    // Completion strobes
    input  logic             done_a,
    input  logic             done_mu,
    input  logic             done_du,
    input  logic             done_ls,
    input  logic [IDX_W-1:0] index_a,
    input  logic [IDX_W-1:0] index_mu,
    input  logic [IDX_W-1:0] index_du,
    input  logic [IDX_W-1:0] index_ls,
    input  logic             wen_au,
    input  logic             wen_mu,
    input  logic             wen_du,
    input  logic             wen_ls,
    input  logic [4:0]       reg_rd_au,
    input  logic [4:0]       reg_rd_mu,
    input  logic [4:0]       reg_rd_du,
    input  logic [4:0]       reg_rd_ls,
    input  logic [31:0]      wdata_au,
    input  logic [31:0]      wdata_mu,
    input  logic [31:0]      wdata_du,
    input  logic [31:0]      wdata_ls,
    input  logic [31:0]      pc_a,
    input  logic [31:0]      pc_mu,
    input  logic [31:0]      pc_du,
    input  logic [31:0]      pc_ls,
    input  logic             exception_a,
    input  logic             exception_mu,
    input  logic             exception_du,
    input  logic             exception_ls,
    // Commit side
    output logic             rf_wen,
    output logic [4:0]       rf_rd,
    output logic [31:0]      rf_wdata,
    output logic             commit_valid,
    output logic [31:0]      commit_pc,
    output logic             exception_out,
    output logic [31:0]      exception_pc,
    output logic             flush
);

    localparam int NUM_UNIT = 4;  // unit slot order: 0=arith, 1=mult, 2=div, 3=load/store

    // Entry storage
    logic             r_valid [NUM_CB_ENTRY];
    logic             r_done  [NUM_CB_ENTRY];
    logic             r_wen   [NUM_CB_ENTRY];
    logic [4:0]       r_rd    [NUM_CB_ENTRY];
    logic [31:0]      r_wdata [NUM_CB_ENTRY];
    logic [31:0]      r_pc    [NUM_CB_ENTRY];
    logic             r_exc   [NUM_CB_ENTRY];

    // Pointers carry an extra wrap bit to tell full from empty
    logic [IDX_W:0]   r_head;
    logic [IDX_W:0]   r_tail;

    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic             w_flush_now;
    logic             w_retire;

    // Unit inputs gathered into arrays so completion is handled uniformly
    logic             w_done  [NUM_UNIT];
    logic [IDX_W-1:0] w_idx   [NUM_UNIT];
    logic             w_wen   [NUM_UNIT];
    logic [4:0]       w_rd    [NUM_UNIT];
    logic [31:0]      w_wdata [NUM_UNIT];
    logic [31:0]      w_pc    [NUM_UNIT];
    logic             w_exc   [NUM_UNIT];

    logic             w_cmp_hit  [NUM_CB_ENTRY];
    logic [1:0]       w_cmp_unit [NUM_CB_ENTRY];

    assign w_done[0]  = done_a;      assign w_done[1]  = done_mu;
    assign w_done[2]  = done_du;     assign w_done[3]  = done_ls;
    assign w_idx[0]   = index_a;     assign w_idx[1]   = index_mu;
    assign w_idx[2]   = index_du;    assign w_idx[3]   = index_ls;
    assign w_wen[0]   = wen_au;      assign w_wen[1]   = wen_mu;
    assign w_wen[2]   = wen_du;      assign w_wen[3]   = wen_ls;
    assign w_rd[0]    = reg_rd_au;   assign w_rd[1]    = reg_rd_mu;
    assign w_rd[2]    = reg_rd_du;   assign w_rd[3]    = reg_rd_ls;
    assign w_wdata[0] = wdata_au;    assign w_wdata[1] = wdata_mu;
    assign w_wdata[2] = wdata_du;    assign w_wdata[3] = wdata_ls;
    assign w_pc[0]    = pc_a;        assign w_pc[1]    = pc_mu;
    assign w_pc[2]    = pc_du;       assign w_pc[3]    = pc_ls;
    assign w_exc[0]   = exception_a; assign w_exc[1]   = exception_mu;
    assign w_exc[2]   = exception_du; assign w_exc[3]  = exception_ls;

    assign w_head_idx  = r_head[IDX_W-1:0];
    assign w_tail_idx  = r_tail[IDX_W-1:0];

    assign full  = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign empty = (r_head == r_tail);

    // Head decisions use registered state only, so a completion never retires in its own cycle
    assign w_flush_now = r_valid[w_head_idx] & r_done[w_head_idx] & r_exc[w_head_idx];
    assign w_retire    = r_valid[w_head_idx] & r_done[w_head_idx] & ~r_exc[w_head_idx];

    assign alloc_gnt   = alloc_req & ~full & ~w_flush_now;
    assign alloc_index = w_tail_idx;

    // Per-entry completion arbitration: later (higher-priority) units overwrite the selection
    always_comb begin
        for (int e = 0; e < NUM_CB_ENTRY; e++) begin
            // NOTE: defaults first so every path assigns a value and no latch is inferred.
            w_cmp_hit[e]  = 1'b0;
            w_cmp_unit[e] = 2'd0;
            for (int u = 0; u < NUM_UNIT; u++) begin
                if (w_done[u] && (w_idx[u] == IDX_W'(e))) begin
                    w_cmp_hit[e]  = 1'b1;
                    w_cmp_unit[e] = 2'(u);
                end
            end
        end
    end

    // Entry array and pointer update: reset, flush, allocate, complete, retire
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_head <= '0;
            r_tail <= '0;
            // NOTE: the whole array is cleared so a reset discards every in-flight entry,
            // not just the pointers; a stale valid/done bit would otherwise complete later.
            for (int e = 0; e < NUM_CB_ENTRY; e++) begin
                r_valid[e] <= 1'b0;
                r_done[e]  <= 1'b0;
                r_wen[e]   <= 1'b0;
                r_rd[e]    <= '0;
                r_wdata[e] <= '0;
                r_pc[e]    <= '0;
                r_exc[e]   <= 1'b0;
            end
        end else if (w_flush_now) begin
            r_head <= '0;
            r_tail <= '0;
            for (int e = 0; e < NUM_CB_ENTRY; e++) begin
                r_valid[e] <= 1'b0;
                r_done[e]  <= 1'b0;
                r_exc[e]   <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignments let the allocate/complete/retire updates below
            // all see the pre-edge state, which is what makes same-cycle alloc+retire safe.
            for (int e = 0; e < NUM_CB_ENTRY; e++) begin
                if (w_cmp_hit[e] && r_valid[e] && !r_done[e]) begin
                    r_done[e]  <= 1'b1;
                    r_wen[e]   <= w_wen[w_cmp_unit[e]];
                    r_rd[e]    <= w_rd[w_cmp_unit[e]];
                    r_wdata[e] <= w_wdata[w_cmp_unit[e]];
                    r_pc[e]    <= w_pc[w_cmp_unit[e]];
                    r_exc[e]   <= w_exc[w_cmp_unit[e]];
                end
            end
            if (alloc_gnt) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= 1'b0;
                r_tail              <= r_tail + (IDX_W+1)'(1);
            end
            if (w_retire) begin
                r_valid[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
                r_head              <= r_head + (IDX_W+1)'(1);
            end
        end
    end

    // Registered commit/exception outputs; strobes pulse, data fields hold their last value
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rf_wen        <= 1'b0;
            rf_rd         <= '0;
            rf_wdata      <= '0;
            commit_valid  <= 1'b0;
            commit_pc     <= '0;
            exception_out <= 1'b0;
            exception_pc  <= '0;
            flush         <= 1'b0;
        end else begin
            commit_valid  <= w_retire;
            rf_wen        <= w_retire & r_wen[w_head_idx] & (r_rd[w_head_idx] != 5'd0);
            exception_out <= w_flush_now;
            flush         <= w_flush_now;
            if (w_retire) begin
                rf_rd     <= r_rd[w_head_idx];
                rf_wdata  <= r_wdata[w_head_idx];
                commit_pc <= r_pc[w_head_idx];
            end
            if (w_flush_now) begin
                exception_pc <= r_pc[w_head_idx];
            end
        end
    end

endmodule

// File: tb/tb_ooo_completion_buffer.sv
// Self-checking bench for ooo_completion_buffer: directed vector table, hand-written
// corner sequences and a randomized run, all compared against an in-order queue model.
module tb_ooo_completion_buffer;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [IW-1:0] alloc_index;
    logic          full, empty;
    logic          done_u  [4];
    logic [IW-1:0] idx_u   [4];
    logic          wen_u   [4];
    logic [4:0]    rd_u    [4];
    logic [31:0]   wdata_u [4];
    logic [31:0]   pc_u    [4];
    logic          exc_u   [4];
    logic          rf_wen;
    logic [4:0]    rf_rd;
    logic [31:0]   rf_wdata;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic          exception_out;
    logic [31:0]   exception_pc;
    logic          flush;

    always #5 CLK = ~CLK;

    ooo_completion_buffer #(.NUM_CB_ENTRY(N)) dut (
        .CLK(CLK), .nRST(nRST),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_index(alloc_index),
        .full(full), .empty(empty),
        .done_a(done_u[0]), .done_mu(done_u[1]), .done_du(done_u[2]), .done_ls(done_u[3]),
        .index_a(idx_u[0]), .index_mu(idx_u[1]), .index_du(idx_u[2]), .index_ls(idx_u[3]),
        .wen_au(wen_u[0]), .wen_mu(wen_u[1]), .wen_du(wen_u[2]), .wen_ls(wen_u[3]),
        .reg_rd_au(rd_u[0]), .reg_rd_mu(rd_u[1]), .reg_rd_du(rd_u[2]), .reg_rd_ls(rd_u[3]),
        .wdata_au(wdata_u[0]), .wdata_mu(wdata_u[1]), .wdata_du(wdata_u[2]), .wdata_ls(wdata_u[3]),
        .pc_a(pc_u[0]), .pc_mu(pc_u[1]), .pc_du(pc_u[2]), .pc_ls(pc_u[3]),
        .exception_a(exc_u[0]), .exception_mu(exc_u[1]),
        .exception_du(exc_u[2]), .exception_ls(exc_u[3]),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .exception_out(exception_out), .exception_pc(exception_pc), .flush(flush)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- Reference model: program-order queue of buffer indices ----------------
    int          m_q[$];
    int          m_tail;
    bit          m_known = 0;
    bit          m_done  [N];
    bit          m_wen   [N];
    bit [4:0]    m_rd    [N];
    bit [31:0]   m_wdata [N];
    bit [31:0]   m_pc    [N];
    bit          m_exc   [N];
    bit          e_cv, e_wen, e_exc;
    bit [4:0]    e_rd;
    bit [31:0]   e_wdata, e_cpc, e_epc;

    // Pre-edge samples of the combinational outputs, visible to directed tests
    logic          s_gnt, s_full, s_empty;
    logic [IW-1:0] s_idx;

    function automatic bit in_flight(input int idx);
        foreach (m_q[k]) if (m_q[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_inputs();
        alloc_req = 1'b0;
        for (int u = 0; u < 4; u++) begin
            done_u[u] = 1'b0; idx_u[u] = '0; wen_u[u] = 1'b0; rd_u[u] = '0;
            wdata_u[u] = '0; pc_u[u] = '0; exc_u[u] = 1'b0;
        end
    endtask

    task automatic drive(input int u, input int idx, input bit wen, input int rd,
                         input logic [31:0] wd, input logic [31:0] pc, input bit exc);
        done_u[u] = 1'b1; idx_u[u] = IW'(idx); wen_u[u] = wen; rd_u[u] = 5'(rd);
        wdata_u[u] = wd; pc_u[u] = pc; exc_u[u] = exc;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic cycle();
        bit fl, rt, gnt;
        int h;
        #1;
        s_gnt = alloc_gnt; s_idx = alloc_index; s_full = full; s_empty = empty;
        fl = 1'b0; rt = 1'b0; h = 0;
        if (m_known) begin
            if (m_q.size() > 0) begin
                h  = m_q[0];
                fl = m_done[h] && m_exc[h];
                rt = m_done[h] && !m_exc[h];
            end
            gnt = alloc_req && (m_q.size() != N) && !fl;
            check("alloc_gnt", 32'(s_gnt), 32'(gnt));
            check("alloc_index", 32'(s_idx), 32'(m_tail));
            check("full", 32'(s_full), 32'(m_q.size() == N));
            check("empty", 32'(s_empty), 32'(m_q.size() == 0));
        end
        if (!nRST) begin
            m_q.delete(); m_tail = 0; m_known = 1'b1;
            e_cv = 0; e_wen = 0; e_exc = 0; e_rd = 0; e_wdata = 0; e_cpc = 0; e_epc = 0;
        end else if (m_known) begin
            e_cv  = rt;
            e_exc = fl;
            e_wen = rt && m_wen[h] && (m_rd[h] != 0);
            if (rt) begin e_rd = m_rd[h]; e_wdata = m_wdata[h]; e_cpc = m_pc[h]; end
            if (fl) e_epc = m_pc[h];
            if (fl) begin
                m_q.delete(); m_tail = 0;
            end else begin
                for (int u = 3; u >= 0; u--) begin
                    if (done_u[u] && in_flight(int'(idx_u[u])) && !m_done[idx_u[u]]) begin
                        m_done[idx_u[u]]  = 1'b1;
                        m_wen[idx_u[u]]   = wen_u[u];
                        m_rd[idx_u[u]]    = rd_u[u];
                        m_wdata[idx_u[u]] = wdata_u[u];
                        m_pc[idx_u[u]]    = pc_u[u];
                        m_exc[idx_u[u]]   = exc_u[u];
                    end
                end
                if (rt) void'(m_q.pop_front());
                if (gnt) begin
                    m_done[m_tail] = 1'b0;
                    m_q.push_back(m_tail);
                    m_tail = (m_tail + 1) % N;
                end
            end
        end
        @(posedge CLK);
        #1;
        if (m_known) begin
            check("commit_valid", 32'(commit_valid), 32'(e_cv));
            check("rf_wen", 32'(rf_wen), 32'(e_wen));
            check("rf_rd", 32'(rf_rd), 32'(e_rd));
            check("rf_wdata", rf_wdata, e_wdata);
            check("commit_pc", commit_pc, e_cpc);
            check("exception_out", 32'(exception_out), 32'(e_exc));
            check("flush", 32'(flush), 32'(e_exc));
            check("exception_pc", exception_pc, e_epc);
        end
    endtask

    // ---------------- Directed vector table ----------------
    typedef struct {
        bit nrst; bit alloc; int unit; int idx; bit wen; int rd; logic [31:0] wd; logic [31:0] pc; bit exc;
        bit x_cv; bit x_wen; int x_rd; logic [31:0] x_wd; logic [31:0] x_cpc;
        bit x_exc; logic [31:0] x_epc; bit x_empty;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit nrst, input bit alloc, input int unit, input int idx, input bit wen,
                       input int rd, input logic [31:0] wd, input logic [31:0] pc, input bit exc,
                       input bit x_cv, input bit x_wen, input int x_rd, input logic [31:0] x_wd,
                       input logic [31:0] x_cpc, input bit x_exc, input logic [31:0] x_epc,
                       input bit x_empty);
        vecs.push_back(vec_t'{nrst, alloc, unit, idx, wen, rd, wd, pc, exc,
                              x_cv, x_wen, x_rd, x_wd, x_cpc, x_exc, x_epc, x_empty});
    endtask

    initial begin
        int commits;
        nRST = 1'b0;
        clear_inputs();

        //   nrst alloc unit idx wen rd wdata   pc      exc | cv wen rd wdata pc     exc epc    empty
        add(0, 0, -1, 0, 0, 0, 0,      0,      0,   0, 0, 0, 0,     0,      0, 0,      1);
        // In-order completion on arith, consecutive commits
        add(1, 1, -1, 0, 0, 0, 0,      0,      0,   0, 0, 0, 0,     0,      0, 0,      0);
        add(1, 1, -1, 0, 0, 0, 0,      0,      0,   0, 0, 0, 0,     0,      0, 0,      0);
        add(1, 1, -1, 0, 0, 0, 0,      0,      0,   0, 0, 0, 0,     0,      0, 0,      0);
        add(1, 0, 0,  0, 1, 5, 'h11,   'h100,  0,   0, 0, 0, 0,     0,      0, 0,      0);
        add(1, 0, 0,  1, 1, 6, 'h22,   'h104,  0,   1, 1, 5, 'h11,  'h100,  0, 0,      0);
        add(1, 0, 0,  2, 1, 7, 'h33,   'h108,  0,   1, 1, 6, 'h22,  'h104,  0, 0,      0);
        add(1, 0, -1, 0, 0, 0, 0,      0,      0,   1, 1, 7, 'h33,  'h108,  0, 0,      1);
        add(1, 0, -1, 0, 0, 0, 0,      0,      0,   0, 0, 7, 'h33,  'h108,  0, 0,      1);
        // Reset, then exception at idx1 after idx0 commits
        add(0, 0, -1, 0, 0, 0, 0,      0,      0,   0, 0, 0, 0,     0,      0, 0,      1);
        for (int k = 0; k < 4; k++)
            add(1, 1, -1, 0, 0, 0, 0,  0,      0,   0, 0, 0, 0,     0,      0, 0,      0);
        add(1, 0, 0,  0, 1, 9, 'h99,   'h1F0,  0,   0, 0, 0, 0,     0,      0, 0,      0);
        add(1, 0, 1,  1, 1, 10, 'hAA,  'h200,  1,   1, 1, 9, 'h99,  'h1F0,  0, 0,      0);
        add(1, 0, -1, 0, 0, 0, 0,      0,      0,   0, 0, 9, 'h99,  'h1F0,  1, 'h200,  1);
        add(1, 0, -1, 0, 0, 0, 0,      0,      0,   0, 0, 9, 'h99,  'h1F0,  0, 'h200,  1);
        // Write to x0 is suppressed at commit
        add(1, 1, -1, 0, 0, 0, 0,      0,      0,   0, 0, 9, 'h99,  'h1F0,  0, 'h200,  0);
        add(1, 0, 0,  0, 1, 0, 'h77,   'h300,  0,   0, 0, 9, 'h99,  'h1F0,  0, 'h200,  0);
        add(1, 0, -1, 0, 0, 0, 0,      0,      0,   1, 0, 0, 'h77,  'h300,  0, 'h200,  1);

        foreach (vecs[i]) begin
            clear_inputs();
            nRST      = vecs[i].nrst;
            alloc_req = vecs[i].alloc;
            if (vecs[i].unit >= 0)
                drive(vecs[i].unit, vecs[i].idx, vecs[i].wen, vecs[i].rd,
                      vecs[i].wd, vecs[i].pc, vecs[i].exc);
            cycle();
            check($sformatf("vec%0d.commit_valid", i), 32'(commit_valid), 32'(vecs[i].x_cv));
            check($sformatf("vec%0d.rf_wen", i), 32'(rf_wen), 32'(vecs[i].x_wen));
            check($sformatf("vec%0d.rf_rd", i), 32'(rf_rd), 32'(vecs[i].x_rd));
            check($sformatf("vec%0d.rf_wdata", i), rf_wdata, vecs[i].x_wd);
            check($sformatf("vec%0d.commit_pc", i), commit_pc, vecs[i].x_cpc);
            check($sformatf("vec%0d.exception_out", i), 32'(exception_out), 32'(vecs[i].x_exc));
            check($sformatf("vec%0d.flush", i), 32'(flush), 32'(vecs[i].x_exc));
            check($sformatf("vec%0d.exception_pc", i), exception_pc, vecs[i].x_epc);
            check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].x_empty));
        end

        // Out-of-order completion across all four units; commits only once idx0 is done
        clear_inputs(); nRST = 1'b0; cycle(); nRST = 1'b1;
        for (int k = 0; k < 4; k++) begin clear_inputs(); alloc_req = 1'b1; cycle(); end
        for (int k = 3; k >= 1; k--) begin
            clear_inputs();
            drive(k, k, 1'b1, k + 1, 32'(k), 32'h400 + 32'(4 * k), 1'b0);
            cycle();
            check("ooo.no_early_commit", 32'(commit_valid), 32'd0);
        end
        clear_inputs(); drive(0, 0, 1'b1, 1, 32'h0, 32'h400, 1'b0); cycle();
        check("ooo.idx0_capture_only", 32'(commit_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            clear_inputs(); cycle();
            check($sformatf("ooo.commit%0d.valid", k), 32'(commit_valid), 32'd1);
            check($sformatf("ooo.commit%0d.pc", k), commit_pc, 32'h400 + 32'(4 * k));
        end

        // Fill to capacity, deny the 17th request, then wrap the tail
        clear_inputs(); nRST = 1'b0; cycle(); nRST = 1'b1;
        for (int k = 0; k < N; k++) begin clear_inputs(); alloc_req = 1'b1; cycle(); end
        clear_inputs(); alloc_req = 1'b1; cycle();
        check("full.flag", 32'(s_full), 32'd1);
        check("full.gnt_denied", 32'(s_gnt), 32'd0);
        clear_inputs(); drive(0, 0, 1'b1, 3, 32'hC0, 32'h500, 1'b0); cycle();
        clear_inputs(); cycle();
        check("full.retire_one", 32'(commit_valid), 32'd1);
        clear_inputs(); alloc_req = 1'b1; cycle();
        check("wrap.gnt", 32'(s_gnt), 32'd1);
        check("wrap.index", 32'(s_idx), 32'd0);
        commits = 0;
        for (int k = 0; k < 40; k++) begin
            clear_inputs();
            alloc_req = (m_q.size() != N);
            foreach (m_q[j]) begin
                if (!m_done[m_q[j]]) begin
                    drive(k % 4, m_q[j], 1'b1, (k % 31) + 1, 32'(k), 32'h600 + 32'(k), 1'b0);
                    break;
                end
            end
            cycle();
            commits += int'(commit_valid);
        end
        check("wrap.commits_happened", 32'(commits > 30), 32'd1);

        // Same-index completion from arith and load/store: load/store wins
        clear_inputs(); nRST = 1'b0; cycle(); nRST = 1'b1;
        clear_inputs(); alloc_req = 1'b1; cycle();
        clear_inputs();
        drive(0, 0, 1'b1, 3, 32'hAAAA, 32'h700, 1'b0);
        drive(3, 0, 1'b1, 4, 32'h5555, 32'h704, 1'b0);
        cycle();
        clear_inputs(); cycle();
        check("prio.rf_wdata", rf_wdata, 32'h5555);
        check("prio.rf_rd", 32'(rf_rd), 32'd4);

        // Reset mid-operation with five entries pending
        for (int k = 0; k < 5; k++) begin clear_inputs(); alloc_req = 1'b1; cycle(); end
        clear_inputs(); drive(1, 2, 1'b1, 8, 32'hBEEF, 32'h800, 1'b0); cycle();
        clear_inputs(); nRST = 1'b0; cycle(); nRST = 1'b1;
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.rf_wdata", rf_wdata, 32'd0);
        check("rst.rf_rd", 32'(rf_rd), 32'd0);
        check("rst.commit_pc", commit_pc, 32'd0);
        check("rst.commit_valid", 32'(commit_valid), 32'd0);

        // Randomized traffic checked by the model every cycle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clear_inputs();
            nRST      = ($urandom % 300) != 0;
            alloc_req = ((cyc / 150) % 2 == 1) ? (($urandom % 8) != 0) : (($urandom % 3) == 0);
            for (int u = 0; u < 4; u++) begin
                if (($urandom % 3) == 0) begin
                    int idx;
                    if (m_q.size() > 0 && ($urandom % 4) != 0) idx = m_q[$urandom % m_q.size()];
                    else idx = int'($urandom % N);
                    drive(u, idx, 1'($urandom % 2), int'($urandom % 32), $urandom, $urandom,
                          ($urandom % 40) == 0);
                end
            end
            cycle();
        end
        nRST = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
